// File: rtl/reduceron_uart_pkg.sv
// Shared definitions for the Reduceron result reporter.
// Contents: the message length, the ASCII codes used in the report line,
// the nibble-to-hex-character helper and the message FSM state type.
package reduceron_uart_pkg;

    localparam int MSG_LEN = 21;

    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_S  = 8'h53;
    localparam logic [7:0] ASCII_H  = 8'h48;
    localparam logic [7:0] ASCII_EQ = 8'h3D;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } msg_state_e;

    // Uppercase hex digit: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'.
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        logic [7:0] ch;
        if (nib < 4'd10) begin
            ch = 8'h30 + {4'h0, nib};
        end else begin
            ch = 8'h37 + {4'h0, nib};
        end
        return ch;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready handshake.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   valid, data  : byte offered by the parent, taken when valid && ready
//   ready        : high when idle or in the last cycle of the stop bit, so a
//                  following byte starts with no idle gap on the line
//   txd          : registered UART line, idle high
module uart_tx_byte #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       txd
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    logic        active_r;
    logic [7:0]  shift_r;
    logic [3:0]  bit_cnt_r;   // 0 = start, 1..8 = data, 9 = stop
    logic [15:0] baud_cnt_r;
    logic        txd_r;
    logic        ready_s;

    // Ready whenever idle, or on the final cycle of the stop bit.
    always_comb begin
        ready_s = 1'b0;
        if (!active_r) begin
            ready_s = 1'b1;
        end else if ((bit_cnt_r == 4'd9) && (baud_cnt_r == BAUD_LAST)) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
    end

    // Bit timing, shifting and line drive.
    always_ff @(posedge clock) begin
        if (reset) begin
            active_r   <= 1'b0;
            shift_r    <= 8'h00;
            bit_cnt_r  <= 4'd0;
            baud_cnt_r <= 16'd0;
            txd_r      <= 1'b1;
        end else if (valid && ready_s) begin
            active_r   <= 1'b1;
            shift_r    <= data;
            bit_cnt_r  <= 4'd0;
            baud_cnt_r <= 16'd0;
            txd_r      <= 1'b0;
        end else if (active_r) begin
            if (baud_cnt_r == BAUD_LAST) begin
                baud_cnt_r <= 16'd0;
                if (bit_cnt_r == 4'd9) begin
                    active_r  <= 1'b0;
                    bit_cnt_r <= 4'd0;
                    txd_r     <= 1'b1;
                end else begin
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                    // Next slot is data bit [bit_cnt_r] or, after bit 7, the stop bit.
                    txd_r     <= (bit_cnt_r == 4'd8) ? 1'b1 : shift_r[bit_cnt_r[2:0]];
                end
            end else begin
                baud_cnt_r <= baud_cnt_r + 16'd1;
            end
        end else begin
            txd_r <= 1'b1;
        end
    end

    assign ready = ready_s;
    assign txd   = txd_r;

endmodule

// File: rtl/reduceron_result_uart.sv
// Reports the Reduceron completion values over a UART line.
// On a rising edge of finish (while idle) result/state/heap are captured and
// the line "R=hhhhh S=hh H=hhhh" CR LF is sent as 8N1, bytes back to back.
// Ports:
//   clock, reset        : system clock, synchronous active-high reset
//   result, state, heap : Reduceron completion buses
//   finish              : completion flag (level)
//   txd                 : UART line, idle high
//   busy                : high while a message is in flight
//   done                : sticky, set when a message has completed
module reduceron_result_uart
    import reduceron_uart_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [17:0] result,
    input  logic [6:0]  state,
    input  logic [14:0] heap,
    input  logic        finish,
    output logic        txd,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] MSG_END_IDX = 5'(MSG_LEN);

    msg_state_e  state_r;
    msg_state_e  state_next_s;
    logic        finish_q_r;
    logic [17:0] snap_result_r;
    logic [6:0]  snap_state_r;
    logic [14:0] snap_heap_r;
    logic [4:0]  byte_idx_r;     // next byte to hand over; MSG_END_IDX once all are queued
    logic        busy_r;
    logic        done_r;

    logic        trigger_s;
    logic        tx_valid_s;
    logic        tx_ready_s;
    logic        tx_accept_s;
    logic        msg_end_s;
    logic [7:0]  tx_byte_s;

    assign trigger_s   = finish && !finish_q_r && (state_r == ST_IDLE);
    assign tx_valid_s  = (state_r == ST_SEND) && (byte_idx_r < MSG_END_IDX);
    assign tx_accept_s = tx_valid_s && tx_ready_s;
    // Serializer is ready again only at the end of the last stop bit.
    assign msg_end_s   = (state_r == ST_SEND) && (byte_idx_r == MSG_END_IDX) && tx_ready_s;

    // Message FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (trigger_s) begin
                    state_next_s = ST_SEND;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (msg_end_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Message FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Edge detect, snapshots, byte index and status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            finish_q_r    <= 1'b0;
            snap_result_r <= 18'h00000;
            snap_state_r  <= 7'h00;
            snap_heap_r   <= 15'h0000;
            byte_idx_r    <= 5'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            finish_q_r <= finish;
            if (trigger_s) begin
                snap_result_r <= result;
                snap_state_r  <= state;
                snap_heap_r   <= heap;
                byte_idx_r    <= 5'd0;
                busy_r        <= 1'b1;
            end else if (msg_end_s) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else if (tx_accept_s) begin
                byte_idx_r <= byte_idx_r + 5'd1;
            end
        end
    end

    // Byte selection for the current message position.
    always_comb begin
        tx_byte_s = ASCII_SP;
        case (byte_idx_r)
            5'd0:    tx_byte_s = ASCII_R;
            5'd1:    tx_byte_s = ASCII_EQ;
            5'd2:    tx_byte_s = hex_to_ascii({2'b00, snap_result_r[17:16]});
            5'd3:    tx_byte_s = hex_to_ascii(snap_result_r[15:12]);
            5'd4:    tx_byte_s = hex_to_ascii(snap_result_r[11:8]);
            5'd5:    tx_byte_s = hex_to_ascii(snap_result_r[7:4]);
            5'd6:    tx_byte_s = hex_to_ascii(snap_result_r[3:0]);
            5'd7:    tx_byte_s = ASCII_SP;
            5'd8:    tx_byte_s = ASCII_S;
            5'd9:    tx_byte_s = ASCII_EQ;
            5'd10:   tx_byte_s = hex_to_ascii({1'b0, snap_state_r[6:4]});
            5'd11:   tx_byte_s = hex_to_ascii(snap_state_r[3:0]);
            5'd12:   tx_byte_s = ASCII_SP;
            5'd13:   tx_byte_s = ASCII_H;
            5'd14:   tx_byte_s = ASCII_EQ;
            5'd15:   tx_byte_s = hex_to_ascii({1'b0, snap_heap_r[14:12]});
            5'd16:   tx_byte_s = hex_to_ascii(snap_heap_r[11:8]);
            5'd17:   tx_byte_s = hex_to_ascii(snap_heap_r[7:4]);
            5'd18:   tx_byte_s = hex_to_ascii(snap_heap_r[3:0]);
            5'd19:   tx_byte_s = ASCII_CR;
            5'd20:   tx_byte_s = ASCII_LF;
            default: tx_byte_s = ASCII_SP;
        endcase
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clock (clock),
        .reset (reset),
        .valid (tx_valid_s),
        .data  (tx_byte_s),
        .ready (tx_ready_s),
        .txd   (txd)
    );

    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_reduceron_result_uart.sv
// Self-checking bench for reduceron_result_uart with a short bit period.
// The expected report line is formatted from the bus values; the line is
// recorded cycle by cycle and decoded as a UART receiver would.
module tb_reduceron_result_uart;

    localparam int B     = 4;
    localparam int NBITS = 210 * B;

    logic        clock = 1'b0;
    logic        reset;
    logic [17:0] result;
    logic [6:0]  state;
    logic [14:0] heap;
    logic        finish;
    logic        txd;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_b [21];
    logic       wav   [NBITS];

    reduceron_result_uart #(.BAUD_DIV(B)) dut (
        .clock  (clock),
        .reset  (reset),
        .result (result),
        .state  (state),
        .heap   (heap),
        .finish (finish),
        .txd    (txd),
        .busy   (busy),
        .done   (done)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic string hx(input int v, input int ndig);
        string digits;
        string s;
        digits = "0123456789ABCDEF";
        s = "";
        for (int i = ndig - 1; i >= 0; i--) begin
            int d;
            d = (v >> (4 * i)) & 15;
            s = {s, digits.substr(d, d)};
        end
        return s;
    endfunction

    // Reference: the report line as text, then CR LF.
    task automatic make_exp(input logic [17:0] r, input logic [6:0] s, input logic [14:0] h);
        string msg;
        msg = {"R=", hx(int'(r), 5), " S=", hx(int'(s), 2), " H=", hx(int'(h), 4)};
        for (int i = 0; i < 19; i++) exp_b[i] = msg[i];
        exp_b[19] = 8'h0D;
        exp_b[20] = 8'h0A;
    endtask

    // Raise finish with new bus values and check the trigger edge response.
    task automatic fire(input logic [17:0] r, input logic [6:0] s, input logic [14:0] h, input bit hold);
        result = r;
        state  = s;
        heap   = h;
        make_exp(r, s, h);
        finish = 1'b1;
        step(1);
        check("trigger_busy", busy, 1'b1);
        check("trigger_txd_idle", txd, 1'b1);
        if (!hold) finish = 1'b0;
    endtask

    // Record one full message starting the cycle after the trigger edge.
    task automatic capture(input string name, input int pulse_at, input logic exp_done);
        int glitches;
        int ferr;
        int busy_low;
        int done_bad;
        logic [7:0] rx;
        glitches = 0;
        ferr     = 0;
        busy_low = 0;
        done_bad = 0;
        for (int k = 0; k < NBITS; k++) begin
            if (pulse_at >= 0 && k == pulse_at) finish = 1'b1;
            if (pulse_at >= 0 && k == pulse_at + 1) finish = 1'b0;
            step(1);
            wav[k] = txd;
            if (busy !== 1'b1) busy_low++;
            if (done !== exp_done) done_bad++;
        end
        check({name, " first_start_bit"}, wav[0], 1'b0);
        for (int t = 0; t < 210; t++)
            for (int c = 1; c < B; c++)
                if (wav[t * B + c] !== wav[t * B]) glitches++;
        for (int k = 0; k < 21; k++) begin
            if (wav[(10 * k) * B] !== 1'b0) ferr++;
            if (wav[(10 * k + 9) * B] !== 1'b1) ferr++;
            for (int j = 0; j < 8; j++) rx[j] = wav[(10 * k + 1 + j) * B];
            check($sformatf("%s byte%0d", name, k), rx, exp_b[k]);
        end
        check({name, " bit_width"}, glitches, 0);
        check({name, " framing"}, ferr, 0);
        check({name, " busy_during"}, busy_low, 0);
        check({name, " done_during"}, done_bad, 0);
        step(1);
        check({name, " busy_after"}, busy, 1'b0);
        check({name, " done_after"}, done, 1'b1);
        check({name, " txd_after"}, txd, 1'b1);
    endtask

    initial begin
        int idle_busy;
        reset  = 1'b1;
        finish = 1'b0;
        result = 18'($urandom);
        state  = 7'($urandom);
        heap   = 15'($urandom);

        // Reset held for 3 cycles while inputs toggle.
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("reset_txd", txd, 1'b1);
            check("reset_busy", busy, 1'b0);
            check("reset_done", done, 1'b0);
            finish = ~finish;
            result = 18'($urandom);
            state  = 7'($urandom);
            heap   = 15'($urandom);
        end
        reset  = 1'b0;
        finish = 1'b0;
        step(1);
        check("post_reset_txd", txd, 1'b1);
        check("post_reset_busy", busy, 1'b0);
        check("post_reset_done", done, 1'b0);

        // Basic message from a one-cycle finish pulse.
        fire(18'h2ABCD, 7'h45, 15'h1234, 1'b0);
        capture("basic", -1, 1'b0);

        // Bus change right after the trigger must not leak into the message.
        fire(18'h2ABCD, 7'h45, 15'h1234, 1'b0);
        result = 18'h00000;
        capture("snapshot", -1, 1'b1);

        // A finish pulse mid-transmission is ignored.
        fire(18'h0F00F, 7'h0A, 15'h4321, 1'b0);
        capture("pulse_ignored", 100, 1'b1);
        step(3);
        check("pulse_not_queued", busy, 1'b0);

        // finish held high for 2000 cycles yields a single message.
        fire(18'h15A5A, 7'h3C, 15'h6B6B, 1'b1);
        capture("level", -1, 1'b1);
        idle_busy = 0;
        for (int i = 0; i < 2000 - NBITS - 2; i++) begin
            step(1);
            if (busy !== 1'b0 || txd !== 1'b1) idle_busy++;
        end
        check("level_single_msg", idle_busy, 0);
        finish = 1'b0;
        step(1);

        // Re-arm with all-ones values; done stays set.
        fire(18'h3FFFF, 7'h7F, 15'h7FFF, 1'b0);
        capture("rearm_max", -1, 1'b1);

        // Random values.
        for (int n = 0; n < 2; n++) begin
            fire(18'($urandom), 7'($urandom), 15'($urandom), 1'b0);
            capture($sformatf("random%0d", n), -1, 1'b1);
            step(int'($urandom_range(1, 5)));
        end

        // Reset during byte 5, finish held through the release.
        fire(18'($urandom), 7'($urandom), 15'($urandom), 1'b1);
        step(210);
        check("pre_abort_busy", busy, 1'b1);
        reset = 1'b1;
        step(1);
        check("abort_txd", txd, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        result = 18'($urandom);
        state  = 7'($urandom);
        heap   = 15'($urandom);
        make_exp(result, state, heap);
        step(1);
        reset = 1'b0;
        step(1);
        check("restart_busy", busy, 1'b1);
        check("restart_txd_idle", txd, 1'b1);
        capture("after_abort", -1, 1'b0);
        finish = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
